// File: rtl/rv_dbgbridge.sv
// Host-link debug bridge: decodes halt/go/read/write byte commands and issues
// single-word transfers on the data-memory bus while the core is halted.
module rv_dbgbridge #(
  parameter int TIMEOUT       = 600000,
  parameter bit HALT_ON_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        xreset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halt,
  output logic [31:0] m_adr,
  output logic        m_re,
  output logic [3:0]  m_we,
  output logic [31:0] m_dw,
  input  logic [31:0] m_dr,
  input  logic        m_rdy
);

  // state    | meaning
  // S_IDLE   | waiting for an opcode byte
  // S_ADDR   | collecting 4 address bytes, LSB first
  // S_DATA   | collecting 4 write-data bytes, LSB first
  // S_BUS    | request driven until the responder is ready
  // S_RDWAIT | read data returns this cycle and is captured
  // S_REPLY  | reply bytes presented to the host link
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_BUS, S_RDWAIT, S_REPLY
  } state_t;

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);
  localparam logic [7:0]    C_ACK    = 8'h06;
  localparam logic [7:0]    C_NAK    = 8'h15;
  localparam logic [7:0]    OP_H     = 8'h48;
  localparam logic [7:0]    OP_G     = 8'h47;
  localparam logic [7:0]    OP_R     = 8'h52;
  localparam logic [7:0]    OP_W     = 8'h57;

  state_t        r_state, w_next;
  logic          r_live;
  logic          r_halt;
  logic          r_is_wr;
  logic [1:0]    r_cnt;
  logic [TW-1:0] r_tmo;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_txbuf;
  logic          w_rx_acc;
  logic          w_tx_acc;
  logic          w_collect;
  logic          w_tmo_hit;

  // r_live keeps rx_ready low while reset is asserted even though the state is IDLE
  assign rx_ready  = r_live & (r_state inside {S_IDLE, S_ADDR, S_DATA});
  assign w_rx_acc  = rx_valid & rx_ready;
  assign tx_valid  = (r_state == S_REPLY);
  assign w_tx_acc  = tx_valid & tx_ready;
  assign tx_data   = r_txbuf[7:0];
  assign w_collect = (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_tmo_hit = w_collect & ~w_rx_acc & (r_tmo == '0);

  assign halt  = r_halt;
  assign m_adr = r_addr & 32'hFFFF_FFFC;
  assign m_dw  = r_wdata;
  assign m_re  = (r_state == S_BUS) & ~r_is_wr;
  assign m_we  = {4{(r_state == S_BUS) & r_is_wr}};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rx_acc) begin
          if (rx_data == OP_R || rx_data == OP_W) w_next = S_ADDR;
          else                                    w_next = S_REPLY;
        end
      end
      S_ADDR: begin
        if (w_rx_acc && r_cnt == 2'd3) begin
          if (r_is_wr)     w_next = S_DATA;
          else if (r_halt) w_next = S_BUS;
          else             w_next = S_REPLY;
        end else if (w_tmo_hit) begin
          w_next = S_IDLE;
        end
      end
      S_DATA: begin
        if (w_rx_acc && r_cnt == 2'd3) w_next = r_halt ? S_BUS : S_REPLY;
        else if (w_tmo_hit)            w_next = S_IDLE;
      end
      S_BUS: begin
        if (m_rdy) w_next = r_is_wr ? S_REPLY : S_RDWAIT;
      end
      S_RDWAIT: w_next = S_REPLY;
      S_REPLY: begin
        if (w_tx_acc && r_cnt == 2'd0) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
      r_halt  <= HALT_ON_RESET;
      r_is_wr <= 1'b0;
      r_cnt   <= 2'd0;
      r_tmo   <= '0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_txbuf <= 32'h0;
    end else begin
      r_live  <= 1'b1;
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_rx_acc) begin
            r_cnt   <= 2'd0;
            r_tmo   <= TMO_LOAD;
            r_is_wr <= (rx_data == OP_W);
            r_txbuf <= {24'h0, (rx_data == OP_H || rx_data == OP_G) ? C_ACK : C_NAK};
            if (rx_data == OP_H) r_halt <= 1'b1;
            if (rx_data == OP_G) r_halt <= 1'b0;
          end
        end
        S_ADDR, S_DATA: begin
          if (w_rx_acc) begin
            if (r_state == S_ADDR) r_addr  <= {rx_data, r_addr[31:8]};
            else                   r_wdata <= {rx_data, r_wdata[31:8]};
            r_cnt   <= r_cnt + 2'd1;
            r_tmo   <= TMO_LOAD;
            // only presented if the command ends unhalted; otherwise overwritten
            r_txbuf <= {24'h0, C_NAK};
          end else if (r_tmo != '0) begin
            r_tmo <= r_tmo - 1'b1;
          end
        end
        S_BUS: begin
          if (m_rdy) begin
            r_txbuf <= {24'h0, C_ACK};
            r_cnt   <= 2'd0;
          end
        end
        S_RDWAIT: begin
          r_txbuf <= m_dr;
          r_cnt   <= 2'd3;
        end
        S_REPLY: begin
          if (w_tx_acc) begin
            r_txbuf <= {8'h00, r_txbuf[31:8]};
            if (r_cnt != 2'd0) r_cnt <= r_cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_dbgbridge.sv
// Directed bench for rv_dbgbridge: a command-level model predicts halt, bus
// transfers and reply bytes; a per-cycle compare process checks the DUT.
module tb_rv_dbgbridge;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        xreset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        halt;
  logic [31:0] m_adr;
  logic        m_re;
  logic [3:0]  m_we;
  logic [31:0] m_dw;
  logic [31:0] m_dr;
  logic        m_rdy;

  rv_dbgbridge #(.TIMEOUT(TMO), .HALT_ON_RESET(1'b0)) dut (
    .clk(clk), .xreset(xreset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .halt(halt),
    .m_adr(m_adr), .m_re(m_re), .m_we(m_we), .m_dw(m_dw),
    .m_dr(m_dr), .m_rdy(m_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic        re;
    logic [3:0]  we;
    logic [31:0] dw;
  } bus_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          last_acc = 0;
  int          req_cycles = 0;
  int          we_cycles = 0;
  int          tv_cycles = 0;
  logic        exp_halt = 1'b0;
  logic [31:0] rd_word = 32'h0;
  logic [7:0]  cmd[$];
  logic [7:0]  rq[$];
  logic [7:0]  got[$];
  bus_t        busq[$];

  logic        prev_req = 1'b0;
  logic [31:0] prev_adr, prev_dw;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_tx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Command-level model: invoked on the clock edge that accepts a byte.
  task automatic model_byte(input logic [7:0] b);
    logic [31:0] a, d;
    if (cmd.size() > 0 && (cyc - last_acc) > TMO) cmd.delete();
    last_acc = cyc;
    cmd.push_back(b);
    case (cmd[0])
      8'h48: begin exp_halt = 1'b1; rq.push_back(8'h06); cmd.delete(); end
      8'h47: begin exp_halt = 1'b0; rq.push_back(8'h06); cmd.delete(); end
      8'h52: if (cmd.size() == 5) begin
        a = {cmd[4], cmd[3], cmd[2], cmd[1]};
        if (exp_halt) begin
          busq.push_back('{adr: a & 32'hFFFF_FFFC, re: 1'b1, we: 4'h0, dw: 32'h0});
          for (int i = 0; i < 4; i++) rq.push_back(rd_word[8*i +: 8]);
        end else rq.push_back(8'h15);
        cmd.delete();
      end
      8'h57: if (cmd.size() == 9) begin
        a = {cmd[4], cmd[3], cmd[2], cmd[1]};
        d = {cmd[8], cmd[7], cmd[6], cmd[5]};
        if (exp_halt) begin
          busq.push_back('{adr: a & 32'hFFFF_FFFC, re: 1'b0, we: 4'hF, dw: d});
          rq.push_back(8'h06);
        end else rq.push_back(8'h15);
        cmd.delete();
      end
      default: begin rq.push_back(8'h15); cmd.delete(); end
    endcase
  endtask

  task automatic model_reset();
    exp_halt = 1'b0;
    cmd.delete(); rq.delete(); busq.delete();
  endtask

  // Called away from a posedge; returns 1 ns after the accepting edge.
  task automatic send(input logic [7:0] b);
    bit done = 0;
    rx_data = b; rx_valid = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      if (rx_ready) begin
        @(posedge clk);
        model_byte(b);
        #1;
        done = 1;
      end else @(negedge clk);
    end
    rx_valid = 1'b0;
    if (!done) chk("rx_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_addr(input logic [7:0] op, input logic [31:0] a);
    send(op);
    for (int i = 0; i < 4; i++) send(a[8*i +: 8]);
  endtask

  task automatic send_w(input logic [31:0] a, input logic [31:0] d);
    send_addr(8'h57, a);
    for (int i = 0; i < 4; i++) send(d[8*i +: 8]);
  endtask

  task automatic wait_replies();
    bit done = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (rq.size() == 0 && !tx_valid) done = 1;
    end
    if (!done) chk("reply_drain_timeout", 32'(rq.size()), 32'd0);
    #1;
  endtask

  // Responder: read data valid only in the cycle after the accepted read.
  always @(negedge clk) begin
    if (xreset && m_re && m_rdy) begin
      @(posedge clk); #1 m_dr = rd_word;
      @(posedge clk); #1 m_dr = 32'h5A5A_5A5A;
    end
  end

  always @(negedge clk) begin
    bus_t t;
    logic [7:0] e;
    cyc++;
    if (xreset) begin
      if (tx_valid) tv_cycles++;
      n_checks++;
      if (halt !== exp_halt) begin
        n_errors++;
        $display("FAIL halt: got %b expected %b", halt, exp_halt);
      end
      if (m_re || m_we != 4'h0) begin
        req_cycles++;
        if (m_we != 4'h0) we_cycles++;
        if (prev_req) begin
          n_checks++;
          if (m_adr !== prev_adr || m_dw !== prev_dw) begin
            n_errors++;
            $display("FAIL bus_stable: adr %h dw %h required %h %h", m_adr, m_dw, prev_adr, prev_dw);
          end
        end
        if (m_rdy) begin
          n_checks++;
          if (busq.size() == 0) begin
            n_errors++;
            $display("FAIL bus_unexpected: adr %h re %b we %h required none", m_adr, m_re, m_we);
          end else begin
            t = busq.pop_front();
            if (m_adr !== t.adr || m_re !== t.re || m_we !== t.we || (t.we != 4'h0 && m_dw !== t.dw)) begin
              n_errors++;
              $display("FAIL bus_txn: adr %h re %b we %h dw %h required %h %b %h %h",
                       m_adr, m_re, m_we, m_dw, t.adr, t.re, t.we, t.dw);
            end
          end
        end
        prev_req = 1'b1; prev_adr = m_adr; prev_dw = m_dw;
      end else prev_req = 1'b0;
      if (tx_valid) begin
        if (prev_stall) begin
          n_checks++;
          if (tx_data !== prev_tx) begin
            n_errors++;
            $display("FAIL tx_hold: got %h required %h", tx_data, prev_tx);
          end
        end
        if (tx_ready) begin
          n_checks++;
          got.push_back(tx_data);
          if (rq.size() == 0) begin
            n_errors++;
            $display("FAIL tx_unexpected: got %h required none", tx_data);
          end else begin
            e = rq.pop_front();
            if (tx_data !== e) begin
              n_errors++;
              $display("FAIL tx_byte: got %h required %h", tx_data, e);
            end
          end
        end
        prev_stall = ~tx_ready; prev_tx = tx_data;
        n_checks++;
        if (rx_ready) begin
          n_errors++;
          $display("FAIL rx_ready_in_reply: got 1 required 0");
        end
      end else prev_stall = 1'b0;
    end else begin
      prev_req = 1'b0; prev_stall = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin
    xreset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tx_ready = 1'b1; m_rdy = 1'b1; m_dr = 32'h0;
    #12;
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_m_re", 32'(m_re), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_adr", m_adr, 32'h0);
    chk("rst_m_dw", m_dw, 32'h0);
    @(negedge clk); xreset = 1'b1;
    @(posedge clk); #1;
    chk("rx_ready_after_rst", 32'(rx_ready), 32'd1);

    // halt, then halted write
    send(8'h48);
    chk("halt_rises", 32'(halt), 32'd1);
    wait_replies();
    we_cycles = 0;
    send_w(32'h0000_0010, 32'hDEAD_BEEF);
    chk("wr_bus_we", 32'(m_we), 32'hF);
    chk("wr_bus_adr", m_adr, 32'h0000_0010);
    chk("wr_bus_dw", m_dw, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    chk("wr_ack_latency", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'h06});
    wait_replies();
    chk("wr_we_cycles", 32'(we_cycles), 32'd1);

    // read with unaligned address, responder ready at once
    rd_word = 32'hDEAD_BEEF;
    got.delete();
    send_addr(8'h52, 32'h0000_0013);
    chk("rd_bus_re", 32'(m_re), 32'd1);
    chk("rd_bus_adr", m_adr, 32'h0000_0010);
    @(posedge clk); #1;
    chk("rd_rdwait_no_tx", 32'(tx_valid), 32'd0);
    @(posedge clk); #1;
    chk("rd_first_byte", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'hEF});
    wait_replies();
    chk("rd_bytes", (got.size() == 4) ? {got[3], got[2], got[1], got[0]} : 32'h0, 32'hDEAD_BEEF);

    // read with responder stalled three cycles
    rd_word = 32'h0102_0304;
    m_rdy = 1'b0; req_cycles = 0;
    send_addr(8'h52, 32'h0000_0104);
    repeat (3) @(posedge clk);
    #1 m_rdy = 1'b1;
    wait_replies();
    chk("rd_req_cycles", 32'(req_cycles), 32'd4);

    // link back-pressure during a read reply
    rd_word = 32'hDEAD_BEEF;
    tx_ready = 1'b0;
    send_addr(8'h52, 32'h0000_0020);
    repeat (12) @(posedge clk);
    #1;
    chk("stall_hold", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'hEF});
    tx_ready = 1'b1;
    wait_replies();

    // unhalted write and unknown opcode are refused
    send(8'h47);
    chk("halt_falls", 32'(halt), 32'd0);
    wait_replies();
    we_cycles = 0;
    send_w(32'h0000_0040, 32'h1111_2222);
    wait_replies();
    chk("unhalted_no_we", 32'(we_cycles), 32'd0);
    got.delete();
    send(8'h00);
    wait_replies();
    chk("nak_opcode", (got.size() == 1) ? 32'(got[0]) : 32'hFFFF_FFFF, 32'h15);

    // inter-byte timeout: 16 idle cycles abandon, 15 do not
    send(8'h48);
    wait_replies();
    send(8'h52); send(8'h80); send(8'h00);
    repeat (TMO) @(posedge clk);
    #1;
    chk("tmo_no_reply", 32'(tx_valid), 32'd0);
    got.delete();
    send(8'h48);
    wait_replies();
    chk("tmo_then_ack", (got.size() == 1) ? 32'(got[0]) : 32'hFFFF_FFFF, 32'h06);
    rd_word = 32'hCAFE_F00D;
    send(8'h52); send(8'h80); send(8'h00);
    repeat (TMO - 1) @(posedge clk);
    #1;
    send(8'h00); send(8'h00);
    wait_replies();

    // reset while a request is pending on the bus
    m_rdy = 1'b0;
    send_addr(8'h52, 32'h0000_0200);
    chk("pre_rst_re", 32'(m_re), 32'd1);
    #2 xreset = 1'b0;
    model_reset();
    #1;
    chk("rst_drops_re", 32'(m_re), 32'd0);
    repeat (2) @(negedge clk);
    xreset = 1'b1; m_rdy = 1'b1;
    tv_cycles = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("no_tx_after_rst", 32'(tv_cycles), 32'd0);

    chk("replies_left", 32'(rq.size()), 32'd0);
    chk("bus_left", 32'(busq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
